// File: rtl/resp_packer.sv
// Serialises 8-bit RF and 16-bit ALU responses (LSB first) into TX FIFO bytes; one-entry pending slot.
// Latency: first byte written the cycle after the strobe. Backpressure: FIFO_FULL stalls writes; overflow drops with DROP pulse.
module resp_packer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    WR_INC,
  output logic                    BUSY,
  output logic                    DROP
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_n;
  logic [2*DATA_WIDTH-1:0] act_val, act_val_n, pend_val, pend_val_n, sh_val, new_val;
  logic [1:0]              act_cnt, act_cnt_n, pend_cnt, pend_cnt_n, sh_cnt, new_cnt;
  logic                    pend_v, pend_v_n, drop_q, drop_n, new_vld;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      act_val  <= '0;
      act_cnt  <= '0;
      pend_val <= '0;
      pend_cnt <= '0;
      pend_v   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      act_val  <= act_val_n;
      act_cnt  <= act_cnt_n;
      pend_val <= pend_val_n;
      pend_cnt <= pend_cnt_n;
      pend_v   <= pend_v_n;
      drop_q   <= drop_n;
    end
  end

  always_comb begin
    sh_val     = act_val;
    sh_cnt     = act_cnt;
    act_val_n  = act_val;
    act_cnt_n  = act_cnt;
    pend_val_n = pend_val;
    pend_cnt_n = pend_cnt;
    pend_v_n   = pend_v;
    drop_n     = 1'b0;
    new_vld    = ALU_OUT_VLD | RF_RdData_VLD;
    new_val    = ALU_OUT_VLD ? ALU_OUT : {{DATA_WIDTH{1'b0}}, RF_RdData};
    new_cnt    = ALU_OUT_VLD ? 2'd2 : 2'd1;

    if (WR_INC) begin
      sh_val = act_val >> DATA_WIDTH;
      sh_cnt = act_cnt - 2'd1;
    end
    act_val_n = sh_val;
    act_cnt_n = sh_cnt;

    // Pending refills active on the same edge the last byte leaves, so no bubble.
    if (sh_cnt == 2'd0 && pend_v) begin
      act_val_n = pend_val;
      act_cnt_n = pend_cnt;
      pend_v_n  = 1'b0;
    end

    if (new_vld) begin
      if (act_cnt_n == 2'd0) begin
        act_val_n = new_val;
        act_cnt_n = new_cnt;
      end else if (!pend_v_n) begin
        pend_val_n = new_val;
        pend_cnt_n = new_cnt;
        pend_v_n   = 1'b1;
      end else begin
        drop_n = 1'b1;
      end
    end
    // Colliding RF result loses to the ALU result.
    if (ALU_OUT_VLD && RF_RdData_VLD)
      drop_n = 1'b1;

    state_n = (act_cnt_n != 2'd0) ? SEND : IDLE;
  end

  assign WR_INC  = (state_q == SEND) && !FIFO_FULL;
  assign WR_DATA = act_val[DATA_WIDTH-1:0];
  assign BUSY    = pend_v;
  assign DROP    = drop_q;

endmodule

// File: tb/tb_resp_packer.sv
// Directed bench for resp_packer: per-scenario tasks with hand-computed expected bytes and strobes.
module tb_resp_packer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        FIFO_FULL;
  logic [7:0]  WR_DATA;
  logic        WR_INC;
  logic        BUSY;
  logic        DROP;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] wr_q[$];
  int drop_cnt = 0;
  int full_viol = 0;

  resp_packer #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .FIFO_FULL(FIFO_FULL),
    .WR_DATA(WR_DATA), .WR_INC(WR_INC), .BUSY(BUSY), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (WR_INC) wr_q.push_back(WR_DATA);
    if (DROP) drop_cnt++;
    if (WR_INC && FIFO_FULL) full_viol++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    wr_q.delete();
    drop_cnt  = 0;
    full_viol = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (WR_INC !== 1'b0)   begin n_err++; $display("FAIL reset_wr_inc cyc%0d got %b exp 0", i, WR_INC); end
      n_vec++; if (BUSY !== 1'b0)     begin n_err++; $display("FAIL reset_busy cyc%0d got %b exp 0", i, BUSY); end
      n_vec++; if (DROP !== 1'b0)     begin n_err++; $display("FAIL reset_drop cyc%0d got %b exp 0", i, DROP); end
      n_vec++; if (WR_DATA !== 8'h00) begin n_err++; $display("FAIL reset_wr_data cyc%0d got %h exp 00", i, WR_DATA); end
    end
    RF_RdData_VLD = 1'b0;
    ALU_OUT_VLD   = 1'b0;
    RST           = 1'b0;
    step();
    step();
  endtask

  task automatic test_rf_single();
    clear_log();
    RF_RdData = 8'hA5; RF_RdData_VLD = 1'b1;
    step();
    RF_RdData_VLD = 1'b0;
    n_vec++; if (WR_INC !== 1'b1)   begin n_err++; $display("FAIL rf_wr_inc got %b exp 1", WR_INC); end
    n_vec++; if (WR_DATA !== 8'hA5) begin n_err++; $display("FAIL rf_wr_data got %h exp a5", WR_DATA); end
    step();
    n_vec++; if (WR_INC !== 1'b0)   begin n_err++; $display("FAIL rf_idle_wr_inc got %b exp 0", WR_INC); end
    n_vec++; if (wr_q.size() != 1)  begin n_err++; $display("FAIL rf_byte_count got %0d exp 1", wr_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    logic       exp_busy[3];
    exp_b = '{8'hEF, 8'hBE, 8'h3C};
    exp_busy = '{1'b0, 1'b1, 1'b0};
    clear_log();
    ALU_OUT = 16'hBEEF; ALU_OUT_VLD = 1'b1;
    step();
    ALU_OUT_VLD = 1'b0;
    RF_RdData = 8'h3C; RF_RdData_VLD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (WR_INC !== 1'b1)        begin n_err++; $display("FAIL b2b_wr_inc byte%0d got %b exp 1", i, WR_INC); end
      n_vec++; if (WR_DATA !== exp_b[i])   begin n_err++; $display("FAIL b2b_wr_data byte%0d got %h exp %h", i, WR_DATA, exp_b[i]); end
      n_vec++; if (BUSY !== exp_busy[i])   begin n_err++; $display("FAIL b2b_busy byte%0d got %b exp %b", i, BUSY, exp_busy[i]); end
      step();
      RF_RdData_VLD = 1'b0;
    end
    n_vec++; if (WR_INC !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b exp 0", WR_INC); end
    n_vec++; if (drop_cnt != 0)   begin n_err++; $display("FAIL b2b_drop got %0d exp 0", drop_cnt); end
  endtask

  task automatic test_full_stall();
    clear_log();
    FIFO_FULL = 1'b1;
    ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
    step();
    ALU_OUT_VLD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (WR_INC !== 1'b0)   begin n_err++; $display("FAIL full_wr_inc cyc%0d got %b exp 0", i, WR_INC); end
      n_vec++; if (WR_DATA !== 8'h34) begin n_err++; $display("FAIL full_hold cyc%0d got %h exp 34", i, WR_DATA); end
      step();
    end
    FIFO_FULL = 1'b0;
    #1;
    n_vec++; if (WR_INC !== 1'b1 || WR_DATA !== 8'h34) begin n_err++; $display("FAIL full_lsb got inc=%b dat=%h exp inc=1 dat=34", WR_INC, WR_DATA); end
    step();
    n_vec++; if (WR_INC !== 1'b1 || WR_DATA !== 8'h12) begin n_err++; $display("FAIL full_msb got inc=%b dat=%h exp inc=1 dat=12", WR_INC, WR_DATA); end
    step();
    n_vec++; if (WR_INC !== 1'b0) begin n_err++; $display("FAIL full_idle got %b exp 0", WR_INC); end
    n_vec++; if (full_viol != 0)  begin n_err++; $display("FAIL full_write_while_full got %0d exp 0", full_viol); end
  endtask

  task automatic test_collision();
    clear_log();
    ALU_OUT = 16'h0102; ALU_OUT_VLD = 1'b1;
    RF_RdData = 8'h77;  RF_RdData_VLD = 1'b1;
    step();
    ALU_OUT_VLD = 1'b0; RF_RdData_VLD = 1'b0;
    n_vec++; if (DROP !== 1'b1) begin n_err++; $display("FAIL coll_drop got %b exp 1", DROP); end
    n_vec++; if (WR_INC !== 1'b1 || WR_DATA !== 8'h02) begin n_err++; $display("FAIL coll_lsb got inc=%b dat=%h exp inc=1 dat=02", WR_INC, WR_DATA); end
    step();
    n_vec++; if (WR_INC !== 1'b1 || WR_DATA !== 8'h01) begin n_err++; $display("FAIL coll_msb got inc=%b dat=%h exp inc=1 dat=01", WR_INC, WR_DATA); end
    step();
    step();
    n_vec++; if (drop_cnt != 1)   begin n_err++; $display("FAIL coll_drop_count got %0d exp 1", drop_cnt); end
    n_vec++; if (wr_q.size() != 2) begin n_err++; $display("FAIL coll_byte_count got %0d exp 2", wr_q.size()); end
  endtask

  task automatic test_drop_full();
    logic [7:0] exp_b[4];
    exp_b = '{8'h11, 8'hA1, 8'h22, 8'hB2};
    clear_log();
    FIFO_FULL = 1'b1;
    ALU_OUT = 16'hA111; ALU_OUT_VLD = 1'b1;
    step();
    ALU_OUT = 16'hB222;
    step();
    ALU_OUT = 16'hC333;
    step();
    ALU_OUT_VLD = 1'b0;
    n_vec++; if (DROP !== 1'b1) begin n_err++; $display("FAIL dropfull_drop got %b exp 1", DROP); end
    n_vec++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL dropfull_busy got %b exp 1", BUSY); end
    step();
    n_vec++; if (DROP !== 1'b0) begin n_err++; $display("FAIL dropfull_drop_pulse got %b exp 0", DROP); end
    FIFO_FULL = 1'b0;
    for (int i = 0; i < 6; i++) step();
    n_vec++; if (wr_q.size() != 4) begin n_err++; $display("FAIL dropfull_byte_count got %0d exp 4", wr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < wr_q.size()) begin
        n_vec++; if (wr_q[i] !== exp_b[i]) begin n_err++; $display("FAIL dropfull_byte%0d got %h exp %h", i, wr_q[i], exp_b[i]); end
      end
    end
    n_vec++; if (BUSY !== 1'b0 || WR_INC !== 1'b0) begin n_err++; $display("FAIL dropfull_idle got busy=%b inc=%b exp 0 0", BUSY, WR_INC); end
    n_vec++; if (full_viol != 0) begin n_err++; $display("FAIL dropfull_write_while_full got %0d exp 0", full_viol); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    FIFO_FULL = 1'b1;
    ALU_OUT = 16'h5566; ALU_OUT_VLD = 1'b1;
    step();
    ALU_OUT = 16'h7788;
    step();
    ALU_OUT_VLD = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    FIFO_FULL = 1'b0;
    #1;
    n_vec++; if (WR_INC !== 1'b0 || BUSY !== 1'b0 || WR_DATA !== 8'h00) begin n_err++; $display("FAIL midrst_state got inc=%b busy=%b dat=%h exp 0 0 00", WR_INC, BUSY, WR_DATA); end
    for (int i = 0; i < 4; i++) step();
    n_vec++; if (wr_q.size() != 0) begin n_err++; $display("FAIL midrst_lost_bytes got %0d exp 0", wr_q.size()); end
  endtask

  initial begin
    RST = 1'b1;
    RF_RdData = 8'hFF; RF_RdData_VLD = 1'b1;
    ALU_OUT = 16'hFFFF; ALU_OUT_VLD = 1'b1;
    FIFO_FULL = 1'b0;
    test_reset();
    test_rf_single();
    test_back_to_back();
    test_full_stall();
    test_collision();
    test_drop_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
